reg_bank_8x8: RTL

//   Architectural register bank built from 8-bit registers, with a busy scoreboard.

---
 rtl/reg_bank_if.sv | 31 +++
 rtl/reg_bank_8x8.sv | 67 ++++++
 2 files changed

// File: rtl/reg_bank_if.sv
// Decode/write-back bundle for reg_bank_8x8: read ports, write-back port, issue request and scoreboard view.
// master = pipeline side (decode + write-back), slave = register bank.
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              stall;
    logic [NREGS-1:0]  busy_vec;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_vec
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_vec
    );
endinterface

// File: rtl/reg_bank_8x8.sv
// 8x8 register bank with two combinational read ports, one write-back port and a busy scoreboard.
// Optional macro REG_BANK_BYPASS_EN forwards the write-back value/clear to same-cycle readers.
module reg_bank_8x8 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input logic       clk,
    input logic       rst,
    reg_bank_if.slave bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic              wr_hit;
    logic              fwd1;
    logic              fwd2;
    logic              fwd_rd;
    logic              waw;
    logic              issue_ok;

    assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

`ifdef REG_BANK_BYPASS_EN
    assign fwd1   = wr_hit && (bus.rs1_addr == bus.wr_addr);
    assign fwd2   = wr_hit && (bus.rs2_addr == bus.wr_addr);
    assign fwd_rd = wr_hit && (bus.iss_rd == bus.wr_addr);
`else
    assign fwd1   = 1'b0;
    assign fwd2   = 1'b0;
    assign fwd_rd = 1'b0;
`endif

    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (bus.rs1_addr != '0) bus.rs1_data = fwd1 ? bus.wr_data : regs[bus.rs1_addr];
        if (bus.rs2_addr != '0) bus.rs2_data = fwd2 ? bus.wr_data : regs[bus.rs2_addr];
    end

    assign bus.rs1_busy = busy[bus.rs1_addr] && !fwd1;
    assign bus.rs2_busy = busy[bus.rs2_addr] && !fwd2;
    assign waw          = (bus.iss_rd != '0) && busy[bus.iss_rd] && !fwd_rd;

    // Issue handshake: iss_en is valid, !stall is ready; an issue is taken only
    // when both hold at the rising edge, otherwise decode holds its inputs.
    assign bus.stall    = bus.iss_en && (bus.rs1_busy || bus.rs2_busy || waw);
    assign issue_ok     = bus.iss_en && !bus.stall && (bus.iss_rd != '0);
    assign bus.busy_vec = busy;

    // Clear for the write-back first, then set for the new owner on a same-index collision.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit)   busy_nxt[bus.wr_addr] = 1'b0;
        if (issue_ok) busy_nxt[bus.iss_rd]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            busy <= busy_nxt;
            if (wr_hit) regs[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
